tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter CNT_W, default 26: width of the period counter and divisor.
REQ-002 Parameter DIV_DEFAULT, default 50000000: period in clk cycles after reset (1 Hz at 50 MHz).
REQ-003 Parameter FAST_SHIFT, default 3: fast mode divides the period by 2**FAST_SHIFT.
REQ-004 Port clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port en  input  1  count enable; 0 freezes counter and suppresses pulses.
REQ-007 Port clr  input  1  synchronous restart of the period.
REQ-008 Port div_load  input  1  one-cycle strobe that loads div_val.
REQ-009 Port div_val  input  CNT_W  requested period in cycles.
REQ-010 Port mode  input  2  00 normal, 01 fast, 10 single-step, 11 hold.
REQ-011 Port step  input  1  single-step request; used in mode 10 only.
REQ-012 Port tick  output  1  registered one-cycle pulse at each period end.
REQ-013 Port tick_half  output  1  registered one-cycle pulse at each period midpoint.
REQ-014 Port tick_blink  output  1  registered square wave; toggles on every tick and tick_half.
REQ-015 Port count  output  CNT_W  current counter value.
REQ-016 Port div_err  output  1  registered one-cycle pulse flagging a rejected div_val.

Function
REQ-017 The block SHALL hold divisor div_q; effective period P SHALL be div_q in mode 00, and max(div_q >> FAST_SHIFT, 2) in mode 01.
REQ-018 In modes 00/01 with en=1, count SHALL advance 0..P-1 and then wrap to 0, one step per cycle.
REQ-019 tick SHALL be 1 for exactly the cycle after count moves from P-1 to 0.
REQ-020 tick_half SHALL be 1 for exactly the cycle after count moves from (P>>1)-1 to P>>1.
REQ-021 tick_blink SHALL toggle in the same cycle that tick or tick_half asserts; with even P it is a 50% duty square wave of period P.
REQ-022 div_load with div_val >= 2 SHALL set div_q = div_val on the next edge.
REQ-023 div_load with div_val < 2 SHALL leave div_q unchanged and assert div_err for one cycle.
REQ-024 If count >= P-1 under the new P (after a div_load or mode change), count SHALL wrap to 0 on the next enabled edge and tick SHALL pulse; no count value outside 0..P-1 SHALL persist more than one cycle.
REQ-025 In mode 10, count SHALL hold. Each cycle with step=1 SHALL produce one tick pulse in the following cycle and toggle tick_blink. tick_half SHALL stay 0.
REQ-026 In mode 11, or with en=0, count, tick_blink and div_q loading SHALL behave as follows: count and tick_blink hold; tick and tick_half are 0; div_load still takes effect.
REQ-027 clr=1 SHALL set count=0 and tick_blink=0 on the next edge with no tick or tick_half that cycle. clr SHALL have priority over en, mode, step and wrap.
REQ-028 Simultaneous clr and div_load SHALL perform both: counter cleared and divisor loaded.
REQ-029 Pulse outputs SHALL never be high for two consecutive cycles, except in mode 10 with step held high, which ticks every cycle.
REQ-030 All arithmetic SHALL be unsigned CNT_W-bit. The midpoint compare SHALL use P>>1 (floor).

Reset
REQ-031 While rst_n=0: count=0, div_q=DIV_DEFAULT, tick=0, tick_half=0, tick_blink=0, div_err=0, asynchronously.
REQ-032 After rst_n deasserts (mode 00, en=1), the first tick_half SHALL occur DIV_DEFAULT>>1 cycles after the first active edge and the first tick SHALL occur DIV_DEFAULT cycles after it.
REQ-033 Assertion of rst_n mid-period SHALL abort the period with no pulse emitted.

Verification (DIV_DEFAULT=10, FAST_SHIFT=1, CNT_W=8)
REQ-034 Reset release, mode 00, en=1 for 40 cycles -> tick every 10 cycles; tick_half 5 cycles after each tick; tick_blink period 10, 50% duty.
REQ-035 div_load with div_val=6 when count=8 -> wrap next cycle with tick; then period 6; div_val=1 -> div_err pulse and period unchanged.
REQ-036 Mode 01 with div_q=10 -> period 5; div_q=3 in mode 01 -> period clamps to 2.
REQ-037 Mode 10 with three isolated step pulses -> exactly three ticks, each one cycle after its step; count frozen; tick_blink toggles 3 times.
REQ-038 clr at count=7 together with en toggling -> count=0, tick_blink=0, no pulse; next tick arrives 10 enabled cycles later; en=0 cycles do not advance count.
REQ-039 rst_n pulsed low at count=4 -> all outputs 0 immediately; div_q returns to 10 after a prior load.

Source files
------------

// File: rtl/tick_gen_if.sv
// Control and status bundle for tick_gen: period control inputs and tick outputs.
// The master side drives the controls; the slave side is the tick generator.
interface tick_gen_if #(
  parameter int CNT_W = 26
);
  logic             en;
  logic             clr;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic [1:0]       mode;
  logic             step;
  logic             tick;
  logic             tick_half;
  logic             tick_blink;
  logic [CNT_W-1:0] count;
  logic             div_err;

  modport master (
    output en, clr, div_load, div_val, mode, step,
    input  tick, tick_half, tick_blink, count, div_err
  );

  modport slave (
    input  en, clr, div_load, div_val, mode, step,
    output tick, tick_half, tick_blink, count, div_err
  );
endinterface

// File: rtl/tick_gen.sv
// Programmable period tick generator with midpoint pulse, blink output,
// a fast mode, single-step mode and hold.
module tick_gen #(
  parameter int CNT_W       = 26,
  parameter int DIV_DEFAULT = 50000000,
  parameter int FAST_SHIFT  = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  tick_gen_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_FAST   = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

  mode_t            mode_sel;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] fast_div;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] half_pt;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tick_q;
  logic             tick_d;
  logic             half_q;
  logic             half_d;
  logic             blink_q;
  logic             blink_d;
  logic             err_q;
  logic             load_ok;

  assign mode_sel = mode_t'(bus.mode);
  assign load_ok  = bus.div_val >= MIN_DIV;

  // Effective period; fast mode clamps to 2 so the midpoint stays distinct from the wrap.
  always_comb begin
    fast_div = div_q >> FAST_SHIFT;
    period   = div_q;
    if (mode_sel == MODE_FAST) begin
      period = (fast_div < MIN_DIV) ? MIN_DIV : fast_div;
    end
    last    = period - CNT_W'(1);
    half_pt = period >> 1;
  end

  // Using >= on the wrap folds any out-of-range count (after a shrink) back to 0.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    half_d  = 1'b0;
    blink_d = blink_q;
    if (bus.clr) begin
      count_d = '0;
      blink_d = 1'b0;
    end else if (bus.en) begin
      case (mode_sel)
        MODE_NORMAL, MODE_FAST: begin
          if (count_q >= last) begin
            count_d = '0;
            tick_d  = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
            half_d  = (count_d == half_pt);
          end
        end
        MODE_STEP: tick_d = bus.step;
        default: ;
      endcase
      if (tick_d || half_d) begin
        blink_d = ~blink_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      half_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      half_q  <= half_d;
      blink_q <= blink_d;
    end
  end

  // Divisor loads are accepted regardless of en, mode or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_INIT;
      err_q <= 1'b0;
    end else begin
      err_q <= bus.div_load && !load_ok;
      if (bus.div_load && load_ok) begin
        div_q <= bus.div_val;
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.tick       = tick_q;
  assign bus.tick_half  = half_q;
  assign bus.tick_blink = blink_q;
  assign bus.div_err    = err_q;

endmodule

// File: tb/tb_tick_gen.sv
// Directed testbench for tick_gen with DIV_DEFAULT=10, FAST_SHIFT=1, CNT_W=8.
module tb_tick_gen;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  tick_gen_if #(.CNT_W(CNT_W)) bus();

  tick_gen #(
    .CNT_W(CNT_W),
    .DIV_DEFAULT(10),
    .FAST_SHIFT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.clr = 1'b0; bus.div_load = 1'b0;
    bus.div_val = '0; bus.mode = 2'b00; bus.step = 1'b0;
    rst_n = 1'b0;
    repeat (2) cycle();
    n_cmp++; if (bus.count !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tick got %b want 0", bus.tick); end
    n_cmp++; if (bus.tick_half !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_half got %b want 0", bus.tick_half); end
    n_cmp++; if (bus.tick_blink !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_blink got %b want 0", bus.tick_blink); end
    n_cmp++; if (bus.div_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err got %b want 0", bus.div_err); end
  endtask

  task automatic test_normal();
    int c;
    bus.en = 1'b1; bus.mode = 2'b00;
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      c = i % 10;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), c == 0, c == 5, c >= 5}) begin
        n_bad++;
        $display("[TB] FAIL normal cyc=%0d got cnt=%0d t=%b h=%b b=%b want cnt=%0d t=%b h=%b b=%b",
                 i, bus.count, bus.tick, bus.tick_half, bus.tick_blink, c, c == 0, c == 5, c >= 5);
      end
    end
  endtask

  task automatic test_div_load();
    int c;
    repeat (8) cycle();
    n_cmp++; if (bus.count !== 8'd8) begin n_bad++; $display("[TB] FAIL load_pre got %0d want 8", bus.count); end
    bus.div_load = 1'b1; bus.div_val = 8'd6;
    cycle();
    bus.div_load = 1'b0;
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd9, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("[TB] FAIL load_step got cnt=%0d t=%b want cnt=9 t=0 b=1", bus.count, bus.tick);
    end
    cycle();
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("[TB] FAIL load_wrap got cnt=%0d t=%b b=%b want cnt=0 t=1 b=0", bus.count, bus.tick, bus.tick_blink);
    end
    for (int j = 1; j <= 12; j++) begin
      cycle();
      c = j % 6;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), c == 0, c == 3, c >= 3}) begin
        n_bad++;
        $display("[TB] FAIL period6 cyc=%0d got cnt=%0d t=%b h=%b b=%b want cnt=%0d", j, bus.count, bus.tick, bus.tick_half, bus.tick_blink, c);
      end
    end
    bus.div_load = 1'b1; bus.div_val = 8'd1;
    cycle();
    bus.div_load = 1'b0;
    n_cmp++; if (bus.div_err !== 1'b1) begin n_bad++; $display("[TB] FAIL div_err_set got %b want 1", bus.div_err); end
    n_cmp++; if (bus.count !== 8'd1) begin n_bad++; $display("[TB] FAIL err_count got %0d want 1", bus.count); end
    cycle();
    n_cmp++; if (bus.div_err !== 1'b0) begin n_bad++; $display("[TB] FAIL div_err_clear got %b want 0", bus.div_err); end
    for (int j = 2; j <= 6; j++) begin
      if (j > 2) cycle();
      c = j % 6;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), c == 0, c == 3, c >= 3}) begin
        n_bad++;
        $display("[TB] FAIL keep6 cyc=%0d got cnt=%0d t=%b h=%b b=%b want cnt=%0d", j, bus.count, bus.tick, bus.tick_half, bus.tick_blink, c);
      end
    end
  endtask

  task automatic test_fast();
    int c;
    bus.en = 1'b0; bus.div_load = 1'b1; bus.div_val = 8'd10;
    cycle();
    bus.div_load = 1'b0;
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_blink} !== {8'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("[TB] FAIL fast_hold got cnt=%0d t=%b b=%b want 0/0/0", bus.count, bus.tick, bus.tick_blink);
    end
    bus.mode = 2'b01; bus.en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cycle();
      c = j % 5;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), c == 0, c == 2, c >= 2}) begin
        n_bad++;
        $display("[TB] FAIL fast5 cyc=%0d got cnt=%0d t=%b h=%b b=%b want cnt=%0d", j, bus.count, bus.tick, bus.tick_half, bus.tick_blink, c);
      end
    end
    bus.en = 1'b0; bus.div_load = 1'b1; bus.div_val = 8'd3;
    cycle();
    bus.div_load = 1'b0;
    n_cmp++; if (bus.count !== 8'd0) begin n_bad++; $display("[TB] FAIL clamp_hold got %0d want 0", bus.count); end
    bus.en = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      cycle();
      c = j % 2;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), c == 0, c == 1, c == 1}) begin
        n_bad++;
        $display("[TB] FAIL clamp2 cyc=%0d got cnt=%0d t=%b h=%b b=%b want cnt=%0d", j, bus.count, bus.tick, bus.tick_half, bus.tick_blink, c);
      end
    end
  endtask

  task automatic test_step();
    logic eb;
    bus.mode = 2'b00;
    cycle();
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd1, 1'b0, 1'b1, 1'b1}) begin
      n_bad++; $display("[TB] FAIL step_pre got cnt=%0d h=%b b=%b want 1/1/1", bus.count, bus.tick_half, bus.tick_blink);
    end
    bus.mode = 2'b10; bus.step = 1'b0;
    cycle();
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd1, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("[TB] FAIL step_idle got cnt=%0d t=%b h=%b b=%b want 1/0/0/1", bus.count, bus.tick, bus.tick_half, bus.tick_blink);
    end
    eb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      cycle();
      bus.step = 1'b0;
      eb = ~eb;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd1, 1'b1, 1'b0, eb}) begin
        n_bad++; $display("[TB] FAIL step_tick k=%0d got cnt=%0d t=%b h=%b b=%b want 1/1/0/%b", k, bus.count, bus.tick, bus.tick_half, bus.tick_blink, eb);
      end
      repeat (2) begin
        cycle();
        n_cmp++;
        if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd1, 1'b0, 1'b0, eb}) begin
          n_bad++; $display("[TB] FAIL step_gap k=%0d got cnt=%0d t=%b h=%b b=%b want 1/0/0/%b", k, bus.count, bus.tick, bus.tick_half, bus.tick_blink, eb);
        end
      end
    end
  endtask

  task automatic test_clr();
    int  c;
    int  e;
    logic enb;
    bus.en = 1'b0; bus.div_load = 1'b1; bus.div_val = 8'd10;
    cycle();
    bus.div_load = 1'b0;
    n_cmp++; if (bus.count !== 8'd1) begin n_bad++; $display("[TB] FAIL clr_hold got %0d want 1", bus.count); end
    bus.mode = 2'b00; bus.en = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      cycle();
      c = 1 + j;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), 1'b0, c == 5, c >= 5}) begin
        n_bad++; $display("[TB] FAIL clr_pre cyc=%0d got cnt=%0d h=%b b=%b want cnt=%0d", j, bus.count, bus.tick_half, bus.tick_blink, c);
      end
    end
    bus.clr = 1'b1; bus.en = 1'b0;
    cycle();
    bus.clr = 1'b0;
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("[TB] FAIL clr_apply got cnt=%0d t=%b h=%b b=%b want 0/0/0/0", bus.count, bus.tick, bus.tick_half, bus.tick_blink);
    end
    e = 0;
    for (int k = 0; k < 20; k++) begin
      enb = (k % 2 == 0);
      bus.en = enb;
      cycle();
      if (enb) e++;
      c = e % 10;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), enb && c == 0, enb && c == 5, c >= 5}) begin
        n_bad++;
        $display("[TB] FAIL en_toggle k=%0d got cnt=%0d t=%b h=%b b=%b want cnt=%0d", k, bus.count, bus.tick, bus.tick_half, bus.tick_blink, c);
      end
    end
    bus.en = 1'b1;
    repeat (3) cycle();
    n_cmp++; if (bus.count !== 8'd3) begin n_bad++; $display("[TB] FAIL clr_load_pre got %0d want 3", bus.count); end
    bus.clr = 1'b1; bus.div_load = 1'b1; bus.div_val = 8'd4;
    cycle();
    bus.clr = 1'b0; bus.div_load = 1'b0;
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("[TB] FAIL clr_load got cnt=%0d t=%b b=%b want 0/0/0", bus.count, bus.tick, bus.tick_blink);
    end
    for (int j = 1; j <= 4; j++) begin
      cycle();
      c = j % 4;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), c == 0, c == 2, c >= 2}) begin
        n_bad++; $display("[TB] FAIL period4 cyc=%0d got cnt=%0d t=%b h=%b b=%b want cnt=%0d", j, bus.count, bus.tick, bus.tick_half, bus.tick_blink, c);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    bus.div_load = 1'b1; bus.div_val = 8'd6;
    cycle();
    bus.div_load = 1'b0;
    repeat (3) cycle();
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {8'd4, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("[TB] FAIL mid_pre got cnt=%0d b=%b want 4/1", bus.count, bus.tick_blink);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink, bus.div_err} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("[TB] FAIL mid_reset got cnt=%0d t=%b h=%b b=%b e=%b want all 0", bus.count, bus.tick, bus.tick_half, bus.tick_blink, bus.div_err);
    end
    cycle();
    rst_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cycle();
      c = j % 10;
      n_cmp++;
      if ({bus.count, bus.tick, bus.tick_half, bus.tick_blink} !== {CNT_W'(c), c == 0, c == 5, c >= 5}) begin
        n_bad++; $display("[TB] FAIL post_reset cyc=%0d got cnt=%0d t=%b h=%b b=%b want cnt=%0d", j, bus.count, bus.tick, bus.tick_half, bus.tick_blink, c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div_load();
    test_fast();
    test_step();
    test_clr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] timeout");
  end

endmodule
